stack_queue_buffer: RTL and testbench
=====================================

Name: stack_queue_buffer

Overview:
- Parametrised single-clock data buffer, runtime-selectable between LIFO (stack) and FIFO (queue) order.
- Successor to the fixed 8-bit/256-entry push/pop stack.
- Adds:
  - configurable width and depth;
  - ready/valid handshakes;
  - single-cycle push and pop, with simultaneous push+pop;
  - full/empty/almost-full flags, occupancy count, sticky error flags, flush.
- Sits between the top-level pin wrapper and the user-visible IO.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; must be a power of two, at least 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  requested order: 0 = FIFO, 1 = LIFO. Sampled only when empty.
- flush  in  1  synchronous clear of pointers and count.
- push_valid  in  1  push request.
- push_data  in  WIDTH  word to store.
- push_ready  out  1  equals !full.
- pop_valid  in  1  pop request.
- pop_ready  out  1  equals !empty.
- rd_data  out  WIDTH  popped word, registered.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- clear_err  in  1  clears overflow and underflow.
- mode_q  out  1  the order currently in effect.

Behaviour:
- Reset values:
  - count=0, empty=1, full=0, almost_full=0;
  - rd_data=0, rd_valid=0;
  - overflow=0, underflow=0;
  - mode_q=0 (FIFO).
- Memory contents are not cleared by reset or flush and are undefined after reset.
- Priority each cycle: reset > flush > push/pop.
- Flush:
  - sets wr_ptr=rd_ptr=0 and count=0;
  - any push or pop in the same cycle is ignored and rd_valid=0;
  - mode_q loads mode in the flush cycle.
- Acceptance:
  - push is accepted when push_valid && push_ready;
  - pop is accepted when pop_valid && pop_ready;
  - readiness is evaluated on the pre-edge state. A push while full is refused even if a pop is accepted in the same cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- FIFO mode:
  - push writes mem[wr_ptr], then wr_ptr++;
  - pop registers mem[rd_ptr] into rd_data, then rd_ptr++.
- LIFO mode:
  - push writes mem[wr_ptr], then wr_ptr++;
  - pop registers mem[wr_ptr-1] into rd_data, then wr_ptr--;
  - rd_ptr is unused.
- Simultaneous push+pop, both accepted:
  - FIFO: both proceed and count is unchanged.
  - LIFO: rd_data gets the old top and the new word overwrites mem[wr_ptr-1]; wr_ptr and count are unchanged.
- Pop latency: pop accepted on edge N gives rd_data/rd_valid at N+1. rd_data holds its last value when rd_valid=0.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither. Flags are combinational from count.
- Mode:
  - mode_q <= mode only on a cycle where empty is 1 (pre-edge) or flush is 1;
  - a mode change while non-empty is ignored until the buffer drains;
  - switching while empty needs no pointer fixup, because rd_ptr==wr_ptr.
- Errors:
  - overflow sets on push_valid && full;
  - underflow sets on pop_valid && empty;
  - clear_err clears both, but a same-cycle set wins over the clear;
  - flush does not clear the error flags.
- Reset asserted mid-operation: the next state is the reset state and no write occurs that cycle.

Decomposition:
- Package stack_queue_pkg holds:
  - MODE_FIFO=1'b0 and MODE_LIFO=1'b1;
  - a function for the address width, $clog2(DEPTH).
- Sub-module sq_mem:
  - WIDTH x DEPTH register array;
  - one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata);
  - the top level registers the read output.
- Everything else (pointers, count, flags, mode) stays in the top level.

Test Plan (WIDTH=8, DEPTH=4, AF_THRESH=3):
- Reset, then FIFO: push 0x11, 0x22, 0x33, 0x44 → full=1, count=4, almost_full=1; pop x4 → rd_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, each one cycle after its pop; empty=1.
- LIFO (mode=1 while empty): push 0xA1, 0xA2, 0xA3; pop x3 → 0xA3, 0xA2, 0xA1; mode_q=1.
- Wrap in FIFO: push 3, pop 2, push 3 → full; pop 4 → order preserved across the wrap, count back to 0.
- Simultaneous ops:
  - LIFO holding [0x05, 0x06]: push 0x07 with pop → rd_data=0x06, count stays 2, next pop returns 0x07;
  - FIFO full: push+pop → push refused, overflow=1, count=3.
- Errors and flush:
  - pop while empty → underflow=1, rd_valid=0;
  - clear_err → flags 0;
  - flush with count=3 → count=0, empty=1.
- Mode lock and reset: in FIFO with count=2, drive mode=1 → mode_q stays 0 until the last pop leaves the buffer empty, then becomes 1. Reset asserted during a push → count=0, no rd_valid.

Source files
------------

// File: rtl/stack_queue_pkg.sv
// Shared constants and helpers for the stack/queue buffer.
package stack_queue_pkg;

   localparam logic MODE_FIFO = 1'b0;
   localparam logic MODE_LIFO = 1'b1;

   // Pointer width for a buffer of the given depth.
   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sq_mem.sv
// Register-array storage: one synchronous write port, one combinational read port.
module sq_mem
   import stack_queue_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; occupancy tracking makes stale data unreachable.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_queue_buffer.sv
// Single-clock buffer, runtime-selectable FIFO or LIFO order, ready/valid handshakes.
module stack_queue_buffer
   import stack_queue_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic                   flush,
   input  logic                   push_valid,
   input  logic [WIDTH-1:0]       push_data,
   output logic                   push_ready,
   input  logic                   pop_valid,
   output logic                   pop_ready,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clear_err,
   output logic                   mode_q
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr, rd_ptr, top_ptr;
   logic [CW-1:0]    cnt;
   logic             push_acc, pop_acc, lifo;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr, mem_raddr;
   logic [WIDTH-1:0] mem_rdata;
   // [0] = pop accepted this cycle, [1] = registered read result valid
   logic [1:0]       vld_pipe;

   assign count       = cnt;
   assign full        = (cnt == CW'(DEPTH));
   assign empty       = (cnt == '0);
   assign almost_full = (cnt >= CW'(AF_THRESH));
   assign push_ready  = ~full;
   assign pop_ready   = ~empty;

   // Readiness comes from pre-edge state; flush swallows any request in its cycle.
   assign push_acc = push_valid & push_ready & ~flush;
   assign pop_acc  = pop_valid & pop_ready & ~flush;
   assign lifo     = (mode_q == MODE_LIFO);
   assign top_ptr  = wr_ptr - AW'(1);

   assign vld_pipe[0] = pop_acc;
   assign rd_valid    = vld_pipe[1];

   // Address steering: LIFO reads the top and, on push+pop, overwrites it in place.
   always_comb begin
      mem_we    = push_acc & ~reset;
      mem_waddr = (lifo && pop_acc) ? top_ptr : wr_ptr;
      mem_raddr = lifo ? top_ptr : rd_ptr;
   end

   sq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (push_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // Pointer update; rd_ptr sits idle in LIFO and equals wr_ptr whenever empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (lifo) begin
         if (push_acc && !pop_acc)      wr_ptr <= wr_ptr + AW'(1);
         else if (pop_acc && !push_acc) wr_ptr <= top_ptr;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + AW'(1);
         if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Occupancy: net change of accepted push and pop.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         cnt <= '0;
      end else begin
         case ({push_acc, pop_acc})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Registered read port; data holds between pops.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data     <= '0;
         vld_pipe[1] <= 1'b0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         if (pop_acc) rd_data <= mem_rdata;
      end
   end

   // Order may only change while drained (or on flush), so no pointer fixup is needed.
   always_ff @(posedge clk) begin
      if (reset)               mode_q <= MODE_FIFO;
      else if (empty || flush) mode_q <= mode;
   end

   // Sticky error flags; a same-cycle set beats clear_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (push_valid & full)  | (overflow  & ~clear_err);
         underflow <= (pop_valid  & empty) | (underflow & ~clear_err);
      end
   end

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Directed bench for stack_queue_buffer (WIDTH=8, DEPTH=4, AF_THRESH=3).
module tb_stack_queue_buffer;

   logic       clk = 1'b0;
   logic       reset, mode, flush, push_valid, pop_valid, clear_err;
   logic [7:0] push_data;
   logic       push_ready, pop_ready, rd_valid, full, empty, almost_full;
   logic       overflow, underflow, mode_q;
   logic [7:0] rd_data;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stack_queue_buffer #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .flush       (flush),
      .push_valid  (push_valid),
      .push_data   (push_data),
      .push_ready  (push_ready),
      .pop_valid   (pop_valid),
      .pop_ready   (pop_ready),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .overflow    (overflow),
      .underflow   (underflow),
      .clear_err   (clear_err),
      .mode_q      (mode_q)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      push_valid = 1'b1;
      push_data  = d;
      tick();
      push_valid = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] d);
      pop_valid = 1'b1;
      tick();
      pop_valid = 1'b0;
      chk({tag, "_vld"}, rd_valid, 1);
      chk(tag, rd_data, d);
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; flush = 1'b0; push_valid = 1'b0;
      pop_valid = 1'b0; clear_err = 1'b0; push_data = 8'h00;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset state
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      chk("rst_mode_q", mode_q, 0);

      // FIFO fill and drain
      push(8'h11); push(8'h22);
      chk("fifo_af_at2", almost_full, 0);
      push(8'h33);
      chk("fifo_af_at3", almost_full, 1);
      chk("fifo_full_at3", full, 0);
      push(8'h44);
      chk("fifo_full", full, 1);
      chk("fifo_count4", count, 4);
      chk("fifo_af", almost_full, 1);
      chk("fifo_push_ready", push_ready, 0);
      pop_valid = 1'b1;
      tick(); chk("fifo_pop0_vld", rd_valid, 1); chk("fifo_pop0", rd_data, 8'h11);
      tick(); chk("fifo_pop1", rd_data, 8'h22);
      tick(); chk("fifo_pop2", rd_data, 8'h33);
      tick(); chk("fifo_pop3", rd_data, 8'h44);
      pop_valid = 1'b0;
      chk("fifo_empty", empty, 1);
      tick();
      chk("fifo_vld_pulse", rd_valid, 0);
      chk("fifo_rd_hold", rd_data, 8'h44);
      chk("fifo_no_unf", underflow, 0);

      // LIFO
      mode = 1'b1;
      push(8'hA1);
      chk("lifo_mode_q", mode_q, 1);
      push(8'hA2); push(8'hA3);
      pop_expect("lifo_pop0", 8'hA3);
      pop_expect("lifo_pop1", 8'hA2);
      pop_expect("lifo_pop2", 8'hA1);
      chk("lifo_empty", empty, 1);

      // LIFO simultaneous push+pop
      push(8'h05); push(8'h06);
      push_valid = 1'b1; push_data = 8'h07; pop_valid = 1'b1;
      tick();
      push_valid = 1'b0; pop_valid = 1'b0;
      chk("lifo_pp_rd", rd_data, 8'h06);
      chk("lifo_pp_count", count, 2);
      pop_expect("lifo_pp_next", 8'h07);
      pop_expect("lifo_pp_last", 8'h05);
      chk("lifo_pp_empty", empty, 1);

      // FIFO wrap
      mode = 1'b0;
      push(8'hB1);
      chk("wrap_mode_q", mode_q, 0);
      push(8'hB2); push(8'hB3);
      pop_expect("wrap_pop0", 8'hB1);
      pop_expect("wrap_pop1", 8'hB2);
      push(8'hB4); push(8'hB5); push(8'hB6);
      chk("wrap_full", full, 1);
      pop_expect("wrap_pop2", 8'hB3);
      pop_expect("wrap_pop3", 8'hB4);
      pop_expect("wrap_pop4", 8'hB5);
      pop_expect("wrap_pop5", 8'hB6);
      chk("wrap_count0", count, 0);

      // FIFO full, push+pop: push refused
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      push_valid = 1'b1; push_data = 8'hC5; pop_valid = 1'b1;
      tick();
      push_valid = 1'b0; pop_valid = 1'b0;
      chk("full_pp_rd", rd_data, 8'hC1);
      chk("full_pp_count", count, 3);
      chk("full_pp_ovf", overflow, 1);
      clear_err = 1'b1; tick(); clear_err = 1'b0;
      chk("clr_ovf", overflow, 0);

      // Flush with count=3, pop in the same cycle ignored
      flush = 1'b1; pop_valid = 1'b1;
      tick();
      flush = 1'b0; pop_valid = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_rd_valid", rd_valid, 0);
      chk("flush_no_unf", underflow, 0);

      // Underflow, clear, set-beats-clear
      pop_valid = 1'b1; tick(); pop_valid = 1'b0;
      chk("unf_set", underflow, 1);
      chk("unf_rd_valid", rd_valid, 0);
      pop_valid = 1'b1; clear_err = 1'b1; tick(); pop_valid = 1'b0;
      chk("unf_set_wins", underflow, 1);
      tick(); clear_err = 1'b0;
      chk("unf_clr", underflow, 0);

      // Flush leaves FIFO pointers at 0; order continues from there
      push(8'hD1); push(8'hD2);
      mode = 1'b1;
      tick();
      chk("lock_mode_q0", mode_q, 0);
      pop_expect("lock_pop0", 8'hD1);
      chk("lock_mode_q1", mode_q, 0);
      pop_expect("lock_pop1", 8'hD2);
      chk("lock_mode_q2", mode_q, 0);
      tick();
      chk("lock_mode_q_drained", mode_q, 1);

      // Reset during push+pop
      push(8'hE1);
      push_valid = 1'b1; push_data = 8'hE2; pop_valid = 1'b1; reset = 1'b1;
      tick();
      push_valid = 1'b0; pop_valid = 1'b0; reset = 1'b0;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_rd_valid", rd_valid, 0);
      chk("mid_rst_mode_q", mode_q, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      mode = 1'b0;
      push(8'hF1);
      pop_expect("post_rst_pop", 8'hF1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
